// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and types for the direct digital synthesiser.
//   PHASE_W   - width of the truncated phase that addresses the sine table
//   LUT_DEPTH - number of quarter-wave table entries (angles 0..pi/2 inclusive)
//   MIDSCALE  - offset-binary zero level of the output sample
//   AMP       - peak amplitude of the sine around MIDSCALE
package dds_pkg;

  localparam int PHASE_W   = 8;
  localparam int LUT_DEPTH = 65;
  localparam int AMP       = 127;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [7:0]         sample_t;

  localparam sample_t MIDSCALE = 8'd128;

endpackage

// File: rtl/dds_sine_lut.sv
// dds_sine_lut: combinational phase-to-sample converter.
// A 65-entry quarter-wave table holds round(127*sin(2*pi*k/256)), k = 0..64.
// The other three quadrants come from mirroring the index and negating the result.
// Ports:
//   i_phase  - 8-bit phase (full circle = 256)
//   o_sample - unsigned offset-binary sample, 128 + round(127*sin), range 1..255
module dds_sine_lut
  import dds_pkg::*;
(
  input  phase_t  i_phase,
  output sample_t o_sample
);

  logic [1:0]        w_quad;
  logic [5:0]        w_k;
  logic [6:0]        w_idx;
  logic [6:0]        w_mag;
  logic signed [7:0] w_sin;

  function automatic logic [6:0] quarter_sine(input logic [6:0] idx);
    logic [6:0] v;
    v = 7'd127;
    case (idx)
      7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
      7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
      7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
      7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
      7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
      7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
      7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
      7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
      7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
      7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
      7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
      7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
      7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
      7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
      7'd64: v = 7'd127;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  assign w_quad = i_phase[7:6];
  assign w_k    = i_phase[5:0];

  // Odd quadrants run the table backwards; 64-k reaches entry 64 at k=0.
  assign w_idx  = w_quad[0] ? (7'd64 - {1'b0, w_k}) : {1'b0, w_k};
  assign w_mag  = quarter_sine(w_idx);

  // Lower half-circle is the negated upper half.
  assign w_sin    = w_quad[1] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
  assign o_sample = MIDSCALE + sample_t'(w_sin);

endmodule

// File: rtl/dds_core.sv
// dds_core: free-running phase accumulator with registered sine output.
// Output frequency is f_clk * FTW / 2^ACC_W, fixed at elaboration.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset (acc=0, Magnitude=128)
//   Magnitude - registered 8-bit offset-binary sine sample
module dds_core
  import dds_pkg::*;
#(
  parameter int          ACC_W = 16,
  parameter int unsigned FTW   = 256
)
(
  input  logic    clk,
  input  logic    rst,
  output sample_t Magnitude
);

  localparam logic [ACC_W-1:0] FTW_C = ACC_W'(FTW);

  logic [ACC_W-1:0] r_acc;
  sample_t          r_mag;
  phase_t           w_phase;
  sample_t          w_sample;

  // Truncated phase, no dither.
  assign w_phase = r_acc[ACC_W-1 -: PHASE_W];

  dds_sine_lut u_lut (
    .i_phase  (w_phase),
    .o_sample (w_sample)
  );

  // Magnitude samples the phase held before this edge's increment,
  // so the first edge after reset still shows midscale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_mag <= MIDSCALE;
    end else begin
      r_acc <= r_acc + FTW_C;
      r_mag <= w_sample;
    end
  end

  assign Magnitude = r_mag;

endmodule

// File: tb/tb_dds_core.sv
module tb_dds_core;

  localparam real PI = 3.14159265358979323846;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mag_def, mag_q, mag_z, mag_h;

  dds_core #(.ACC_W(16), .FTW(256))   u_def (.clk(clk), .rst(rst), .Magnitude(mag_def));
  dds_core #(.ACC_W(16), .FTW(16384)) u_q   (.clk(clk), .rst(rst), .Magnitude(mag_q));
  dds_core #(.ACC_W(16), .FTW(0))     u_z   (.clk(clk), .rst(rst), .Magnitude(mag_z));
  dds_core #(.ACC_W(16), .FTW(32768)) u_h   (.clk(clk), .rst(rst), .Magnitude(mag_h));

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int phase;
    int exp;
  } exp_t;

  exp_t q_def[$];
  int   q_q[$];
  int   q_z[$];
  int   q_h[$];

  int          tests  = 0;
  int          failed = 0;
  int          seen[256];
  int          edge_n;
  logic [15:0] m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Golden model: 128 + round-half-away-from-zero(127*sin(2*pi*p/256)).
  function automatic int golden(input int p);
    real s;
    s = 127.0 * $sin(2.0 * PI * p / 256.0);
    if (s >= 0.0) return 128 + $rtoi($floor(s + 0.5));
    else          return 128 - $rtoi($floor(-s + 0.5));
  endfunction

  // Hand-computed anchor points for FTW=256 (edge number after reset release).
  function automatic int anchor(input int n);
    case (n)
      1:   return 128;
      2:   return 131;
      3:   return 134;
      33:  return 218;
      65:  return 255;
      129: return 128;
      193: return 1;
      257: return 128;
      default: return -1;
    endcase
  endfunction

  function automatic int quarter_seq(input int n);
    case ((n - 1) % 4)
      0: return 128;
      1: return 255;
      2: return 128;
      default: return 1;
    endcase
  endfunction

  task automatic push_reset();
    exp_t e;
    e.n = 0; e.phase = -1; e.exp = 128;
    q_def.push_back(e);
    q_q.push_back(128);
    q_z.push_back(128);
    q_h.push_back(128);
  endtask

  task automatic push_edge();
    exp_t e;
    int   a;
    edge_n++;
    e.n     = edge_n;
    e.phase = int'(m_acc[15:8]);
    a       = anchor(edge_n);
    e.exp   = (a >= 0) ? a : golden(e.phase);
    q_def.push_back(e);
    m_acc   = m_acc + 16'd256;
    q_q.push_back(quarter_seq(edge_n));
    q_z.push_back(128);
    q_h.push_back(128);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      push_edge();
    end
  endtask

  // Monitor: every falling edge, compare each output against its queued expectation.
  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (q_def.size() != 0) begin
      e = q_def.pop_front();
      check($sformatf("def_edge%0d_p%0d", e.n, e.phase), {24'd0, mag_def}, e.exp);
      if (e.phase >= 0) seen[e.phase] = int'(mag_def);
    end
    if (q_q.size() != 0) begin
      v = q_q.pop_front();
      check("ftw16384", {24'd0, mag_q}, v);
    end
    if (q_z.size() != 0) begin
      v = q_z.pop_front();
      check("ftw0", {24'd0, mag_z}, v);
    end
    if (q_h.size() != 0) begin
      v = q_h.pop_front();
      check("ftw32768", {24'd0, mag_h}, v);
    end
  end

  initial begin
    int mn, mx;
    for (int i = 0; i < 256; i++) seen[i] = -1;
    edge_n = 0;
    m_acc  = '0;
    rst    = 1'b0;

    // Reset held with clock running.
    repeat (2) begin
      @(posedge clk);
      push_reset();
    end
    #1;
    check("acc_reset", {16'd0, u_def.r_acc}, 0);

    @(negedge clk);
    rst = 1'b1;
    run(1024);

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_mag_def", {24'd0, mag_def}, 128);
    check("async_mag_q",   {24'd0, mag_q},   128);
    check("async_acc",     {16'd0, u_def.r_acc}, 0);
    #2 rst = 1'b1;
    edge_n = 0;
    m_acc  = '0;
    run(100);

    @(negedge clk);
    #1;

    mn = 256;
    mx = -1;
    for (int p = 0; p < 256; p++) begin
      if (seen[p] < mn) mn = seen[p];
      if (seen[p] > mx) mx = seen[p];
    end
    check("min_sample", mn, 1);
    check("max_sample", mx, 255);
    for (int p = 0; p < 128; p++)
      check($sformatf("symmetry_p%0d", p), seen[p] + seen[p + 128], 256);
    check("queue_drain", q_def.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
